// File: rtl/dot_pipe_pkg.sv
// dot_pipe_pkg: shared types, widths and lane helpers for the dot-product pipeline
package dot_pipe_pkg;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic valid;
    logic mode;
    logic clr;
  } stage_flags_t;
  function automatic int lane_off(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/dp_adder_level.sv
// dp_adder_level: one registered adder-tree level, IN_N inputs to IN_N/2 pairwise sums
module dp_adder_level
  import dot_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IN_N  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [IN_N*WIDTH-1:0]     din,
  input  stage_flags_t              fin,
  output logic [IN_N/2*WIDTH-1:0]   dout,
  output stage_flags_t              fout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout <= '0;
      fout <= '0;
    end else if (en) begin
      for (int j = 0; j < IN_N / 2; j++)
        dout[lane_off(j, WIDTH) +: WIDTH] <= din[lane_off(2 * j, WIDTH) +: WIDTH] +
                                             din[lane_off(2 * j + 1, WIDTH) +: WIDTH];
      fout <= fin;
    end
endmodule

// File: rtl/dot_product_pipe.sv
// dot_product_pipe: pipelined multi-lane dot product with stall and running accumulate
module dot_product_pipe
  import dot_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] a_flat,
  input  logic [LANES*WIDTH-1:0] b_flat,
  input  logic                   acc_mode,
  input  logic                   acc_clr,
  output logic [WIDTH-1:0]       c,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       acc_cnt
);
  localparam int TREE_LVLS = $clog2(LANES);
  logic [LANES*WIDTH-1:0] a_r, b_r, prod;
  stage_flags_t f1, f2, fr;
  logic [WIDTH-1:0] sum, acc, acc_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      f1   <= '0;
      prod <= '0;
      f2   <= '0;
    end else if (en) begin
      a_r <= a_flat;
      b_r <= b_flat;
      f1  <= '{valid: in_valid, mode: acc_mode, clr: acc_clr};
      for (int i = 0; i < LANES; i++)
        prod[lane_off(i, WIDTH) +: WIDTH] <= a_r[lane_off(i, WIDTH) +: WIDTH] *
                                             b_r[lane_off(i, WIDTH) +: WIDTH];
      f2 <= f1;
    end
  for (genvar l = 0; l < TREE_LVLS; l++) begin : g_lvl
    localparam int N = LANES >> l;
    logic [N/2*WIDTH-1:0] d;
    stage_flags_t f;
    if (l == 0) begin : g_in
      dp_adder_level #(.WIDTH(WIDTH), .IN_N(N)) u_lvl (
        .clk(clk), .rst_n(rst_n), .en(en), .din(prod), .fin(f2), .dout(d), .fout(f)
      );
    end else begin : g_in
      dp_adder_level #(.WIDTH(WIDTH), .IN_N(N)) u_lvl (
        .clk(clk), .rst_n(rst_n), .en(en), .din(g_lvl[l-1].d), .fin(g_lvl[l-1].f),
        .dout(d), .fout(f)
      );
    end
  end
  assign sum      = g_lvl[TREE_LVLS-1].d;
  assign fr       = g_lvl[TREE_LVLS-1].f;
  assign acc_next = fr.clr ? sum : acc + sum;
  // acc_clr only matters for accumulating samples; plain samples leave acc/acc_cnt alone
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      c         <= '0;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= fr.valid;
      if (fr.valid) c <= fr.mode ? acc_next : sum;
      if (fr.valid && fr.mode) begin
        acc     <= acc_next;
        acc_cnt <= fr.clr ? CNT_W'(1) : acc_cnt + CNT_W'(acc_cnt != '1);
      end
    end
endmodule

// File: tb/tb_dot_product_pipe.sv
// tb_dot_product_pipe: scoreboard bench for 2-lane/32-bit and 8-lane/16-bit pipelines
module tb_dot_product_pipe;
  typedef struct {
    logic [31:0] c;
    logic [15:0] cnt;
    int          due;
  } exp_t;
  logic clk = 0, rst_n = 0, en = 1;
  logic iv2 = 0, iv8 = 0, mode = 0, clr = 0;
  logic [63:0] a2 = '0, b2 = '0;
  logic [127:0] a8 = '0, b8 = '0;
  logic [31:0] c2;
  logic [15:0] c8, cnt2, cnt8;
  logic ov2, ov8;
  int cyc = 0, n_chk = 0, n_fail = 0, stall_extra = 0;
  exp_t q2[$], q8[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dot_product_pipe #(.WIDTH(32), .LANES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv2), .a_flat(a2), .b_flat(b2),
    .acc_mode(mode), .acc_clr(clr), .c(c2), .out_valid(ov2), .acc_cnt(cnt2)
  );
  dot_product_pipe #(.WIDTH(16), .LANES(8)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv8), .a_flat(a8), .b_flat(b8),
    .acc_mode(1'b0), .acc_clr(1'b0), .c(c8), .out_valid(ov8), .acc_cnt(cnt8)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // a held out_valid under stall is one result; it is consumed on the first enabled cycle
  always @(negedge clk) if (rst_n && en && ov2) begin : mon2
    exp_t e;
    if (q2.size() == 0) chk("l2_spurious_valid", 32'(ov2), 0);
    else begin
      e = q2.pop_front();
      chk("l2_c", c2, e.c);
      chk("l2_acc_cnt", 32'(cnt2), 32'(e.cnt));
      chk("l2_arrival_cycle", cyc, e.due);
    end
  end
  always @(negedge clk) if (rst_n && en && ov8) begin : mon8
    exp_t e;
    if (q8.size() == 0) chk("l8_spurious_valid", 32'(ov8), 0);
    else begin
      e = q8.pop_front();
      chk("l8_c", 32'(c8), e.c);
      chk("l8_acc_cnt", 32'(cnt8), 32'(e.cnt));
      chk("l8_arrival_cycle", cyc, e.due);
    end
  end
  task automatic send2(input logic [31:0] x0, y0, x1, y1, input logic m, cl,
                       input logic [31:0] ec, input logic [15:0] ecnt);
    a2 = {x1, x0}; b2 = {y1, y0}; iv2 = 1; mode = m; clr = cl;
    q2.push_back('{ec, ecnt, cyc + 4 + stall_extra});
    @(posedge clk); #1;
    iv2 = 0; mode = 0; clr = 0;
  endtask
  task automatic send8(input logic [127:0] va, vb, input logic [31:0] ec);
    a8 = va; b8 = vb; iv8 = 1;
    q8.push_back('{ec, 16'd0, cyc + 6});
    @(posedge clk); #1;
    iv8 = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (q2.size() != 0 || q8.size() != 0); i++) @(posedge clk);
    #1 chk("drain_pending_results", q2.size() + q8.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] va, vb;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_c", c2, 0);
    chk("reset_out_valid", 32'(ov2), 0);
    chk("reset_acc_cnt", 32'(cnt2), 0);
    chk("reset_l8_c", 32'(c8), 0);
    rst_n = 1;
    send2(0, 1, 2, 3, 0, 0, 6, 0);
    send2(3, 2, 1, 0, 0, 0, 6, 0);
    drain();
    send2(32'hFFFF_FFFF, 2, 1, 1, 0, 0, 32'hFFFF_FFFF, 0);
    send2(32'hFFFF_FFFF, 2, 2, 1, 0, 0, 32'h0000_0000, 0);
    drain();
    send2(0, 1, 2, 3, 1, 1, 6, 1);
    send2(0, 1, 2, 3, 1, 0, 12, 2);
    send2(0, 1, 2, 3, 1, 0, 18, 3);
    send2(1, 1, 2, 2, 0, 0, 5, 3);
    send2(1, 1, 0, 0, 1, 0, 19, 4);
    drain();
    stall_extra = 3;
    send2(1, 2, 3, 4, 0, 0, 14, 4);
    send2(5, 5, 1, 1, 0, 0, 26, 4);
    stall_extra = 0;
    en = 0;
    repeat (3) @(posedge clk);
    #1 en = 1;
    drain();
    send2(0, 1, 2, 3, 1, 1, 6, 1);
    send2(0, 1, 2, 3, 1, 0, 12, 2);
    send2(0, 1, 2, 3, 1, 0, 18, 3);
    drain();
    send2(0, 1, 2, 3, 1, 0, 24, 4);
    send2(0, 1, 2, 3, 1, 0, 30, 5);
    send2(0, 1, 2, 3, 1, 0, 36, 6);
    #2 rst_n = 0;
    q2.delete();
    #1;
    chk("midreset_c", c2, 0);
    chk("midreset_out_valid", 32'(ov2), 0);
    chk("midreset_acc_cnt", 32'(cnt2), 0);
    @(posedge clk);
    #1 rst_n = 1;
    send2(1, 1, 1, 1, 1, 0, 2, 1);
    drain();
    for (int i = 0; i < 8; i++) begin
      va[i*16 +: 16] = 16'(i + 1);
      vb[i*16 +: 16] = 16'd2;
    end
    send8(va, vb, 72);
    @(posedge clk); #1;
    send8({8{16'd1}}, {8{16'd1}}, 8);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_product_pipe.md
Name: dot_product_pipe

Overview:
Parametrised pipelined dot-product unit. Computes C = sum over i of A_i*B_i across LANES lanes, with a registered multiply stage, a log2(LANES)-level registered adder tree and a final result/accumulate register. It generalises the fixed two-pair pipeline in several ways:
- configurable width and lane count
- valid qualification
- a global stall (enable)
- an optional running-accumulate mode with in-band clear

Parameters:
WIDTH, 32, operand and result width in bits; all arithmetic is modulo 2^WIDTH.
LANES, 2, number of A/B pairs; power of two, >= 2.
TREE_LVLS, $clog2(LANES), derived; adder-tree depth. Not to be overridden.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  pipeline enable; 0 freezes every pipeline register, including valid bits and the accumulator.
in_valid  in  1  qualifies a_flat/b_flat/acc_mode/acc_clr this cycle.
a_flat  in  LANES*WIDTH  lane i operand A at [i*WIDTH +: WIDTH].
b_flat  in  LANES*WIDTH  lane i operand B at [i*WIDTH +: WIDTH].
acc_mode  in  1  1 = add this sample's sum into the accumulator; 0 = output the plain sum.
acc_clr  in  1  with acc_mode=1: accumulator restarts from 0 before adding this sample.
c  out  WIDTH  result.
out_valid  out  1  c holds a new result this cycle.
acc_cnt  out  16  number of samples accumulated since the last clear or reset; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n=0, async): all stage data registers, valid bits, accumulator, c and acc_cnt go to 0 and out_valid goes to 0, regardless of en. Samples in flight are discarded. First sample is accepted on the first rising edge with rst_n=1.
- Stages, each advancing only when en=1:
  - S1: register operands, in_valid, acc_mode and acc_clr.
  - S2: p_i = (A_i*B_i) truncated to WIDTH.
  - T1..T{TREE_LVLS}: pairwise sums, each truncated to WIDTH. Level k adds adjacent pairs of level k-1.
  - R: result register.
- Latency: 3+TREE_LVLS enabled cycles (LANES=2 -> 4). A sample captured at edge k appears on c with out_valid=1 after edge k+4, absent stalls.
- Throughput: one sample per enabled cycle. No back-pressure output; upstream honours en.
- Valid bit travels with the data. Bubbles (in_valid=0) propagate as valid=0, and their data and flags are ignored.
- R-stage update, when the last tree-stage valid=1:
  - acc_mode=0: c <= sum; accumulator and acc_cnt unchanged.
  - acc_mode=1, acc_clr=0: acc <= acc+sum; c <= acc+sum; acc_cnt <= acc_cnt+1 (saturating).
  - acc_mode=1, acc_clr=1: acc <= sum; c <= sum; acc_cnt <= 1.
  - acc_clr with acc_mode=0: ignored.
- When the last tree-stage valid=0 and en=1: out_valid <= 0; c holds its last value.
- Stall: with en=0, out_valid holds its current value and c holds. The bench treats a held out_valid=1 under stall as the same result, not a new one; a result is consumed only on cycles with en=1.
- Overflow and wrap are silent: no saturation and no flag.
- acc_mode and acc_clr are per-sample, pipelined alongside the data. Mixing modes back-to-back is legal.

Decomposition:
- Package dot_pipe_pkg holds:
  - the lane-slice helper function (lane index -> bit offset)
  - the acc_cnt width localparam (16)
  - the stage-valid flag struct/bit layout
- One sub-module, dp_adder_level: a single registered tree level (IN_N inputs -> IN_N/2 outputs, with valid and flags) and an en input. It is instantiated TREE_LVLS times via generate.
- The multiply stage and the R stage stay in the top module.

Test Plan:
1. LANES=2, WIDTH=32. Sample {A1=0,B1=1,A2=2,B2=3} then {A1=3,B1=2,A2=1,B2=0}, acc_mode=0, en=1 -> c=6 with out_valid on cycle 4 after capture, then c=6 on cycle 5; out_valid drops afterwards.
2. Overflow: A1=32'hFFFF_FFFF, B1=2, A2=1, B2=1 -> c=32'hFFFF_FFFF (wraps: FFFF_FFFE+1); a second sample with A2=2 -> c=32'h0000_0000.
3. Accumulate: three back-to-back samples of sum 6, the first with acc_clr=1, all with acc_mode=1 -> c=6,12,18 and acc_cnt=1,2,3. A fourth sample with acc_mode=0, sum 5 -> c=5, acc_cnt stays 3. A fifth with acc_mode=1, acc_clr=0, sum 1 -> c=19.
4. Stall: en=0 for 3 cycles while two samples are in flight -> both results appear exactly 3 cycles later, with unchanged values and no duplicated or lost out_valid pulses on enabled cycles.
5. Reset mid-operation: assert rst_n=0 asynchronously between edges with 3 samples in flight and acc=18 -> c=0, out_valid=0, acc_cnt=0 immediately. Post-reset sample {1,1,1,1} with acc_mode=1, acc_clr=0 -> c=2.
6. LANES=8, WIDTH=16. Lane i has A=i+1, B=2 -> c=72 after 6 cycles. Bubble/valid interleave pattern 1,0,1 -> out_valid pattern 1,0,1.
